// File: rtl/colour_zone_detect.sv
`default_nettype none
// ============================================================================
// Module      : colour_zone_detect
// Description : Per-frame colour screening of an RGB444 pixel stream. The
//               frame is split into NUM_ZONES equal-width vertical strips.
//               Each pixel whose selected channel is strong and whose other
//               two channels are weak is counted against its strip. At the
//               end of every complete frame the per-strip counts, threshold
//               flags, the dominant strip and a summary flag are registered
//               and a one-cycle frame_done pulse is issued.
//
// Ports
//   clk            in   sole clock, rising edge
//   reset          in   asynchronous, active-low reset
//   data_in[11:0]  in   pixel: [11:8] R, [7:4] G, [3:0] B
//   valid          in   data_in carries a pixel this cycle
//   startofpacket  in   frame start; with valid, data_in is pixel (0,0)
//   colour_sel[1:0]in   00 red, 01 green, 10 blue, 11 never matches
//   zone_flags     out  per-zone threshold met in last completed frame
//   zone_counts    out  packed per-zone matched-pixel counts
//   dominant_zone  out  index of zone with largest count (lowest on tie)
//   any_flag       out  OR of zone_flags
//   frame_done     out  one-cycle pulse when results update
//
// Revision    : 1.0 - initial release
// ============================================================================
module colour_zone_detect #(
    parameter int         IMG_WIDTH      = 320,
    parameter int         IMG_HEIGHT     = 240,
    parameter int         NUM_ZONES      = 4,
    parameter int         SCREEN_PERCENT = 80,
    parameter logic [3:0] CH_MIN         = 4'hC,
    parameter logic [3:0] CH_MAX_OTHER   = 4'h4,
    localparam int        c_CW           = $clog2(IMG_WIDTH * IMG_HEIGHT + 1),
    localparam int        c_ZW           = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [11:0]                 data_in,
    input  logic                        valid,
    input  logic                        startofpacket,
    input  logic [1:0]                  colour_sel,
    output logic [NUM_ZONES-1:0]        zone_flags,
    output logic [NUM_ZONES*c_CW-1:0]   zone_counts,
    output logic [c_ZW-1:0]             dominant_zone,
    output logic                        any_flag,
    output logic                        frame_done
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_ZONE_W = IMG_WIDTH / NUM_ZONES;
    localparam int c_ZCW    = (c_ZONE_W > 1) ? $clog2(c_ZONE_W) : 1;
    localparam int c_RW     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [c_ZCW-1:0] c_ZCOL_LAST = c_ZCW'(c_ZONE_W - 1);
    localparam logic [c_ZW-1:0]  c_ZONE_LAST = c_ZW'(NUM_ZONES - 1);
    localparam logic [c_RW-1:0]  c_ROW_LAST  = c_RW'(IMG_HEIGHT - 1);
    localparam logic [c_CW-1:0]  c_ZONE_PIX  = c_CW'(c_ZONE_W * IMG_HEIGHT);
    // Flag threshold in "count * 100" units, kept at 64 bits so the
    // comparison can never overflow for any legal image size.
    localparam logic [63:0]      c_THRESH    = 64'(SCREEN_PERCENT) * 64'(c_ZONE_W) * 64'(IMG_HEIGHT);

    generate
        if ((IMG_WIDTH % NUM_ZONES) != 0) begin : g_bad_zone_split
            $error("colour_zone_detect: NUM_ZONES must divide IMG_WIDTH exactly");
        end
        if ((SCREEN_PERCENT < 1) || (SCREEN_PERCENT > 100)) begin : g_bad_percent
            $error("colour_zone_detect: SCREEN_PERCENT must be within 1..100");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]       r_sel;
    logic [c_ZCW-1:0] r_zcol;   // column within the current zone
    logic [c_ZW-1:0]  r_zone;
    logic [c_RW-1:0]  r_row;
    logic [c_CW-1:0]  r_acc [NUM_ZONES];

    logic [NUM_ZONES-1:0]      r_zone_flags;
    logic [NUM_ZONES*c_CW-1:0] r_zone_counts;
    logic [c_ZW-1:0]           r_dominant_zone;
    logic                      r_any_flag;
    logic                      r_frame_done;

    // ------------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------------
    logic [1:0]       w_sel;
    logic [c_ZCW-1:0] w_zcol;
    logic [c_ZW-1:0]  w_zone;
    logic [c_RW-1:0]  w_row;
    logic [c_ZCW-1:0] w_zcol_next;
    logic [c_ZW-1:0]  w_zone_next;
    logic [c_RW-1:0]  w_row_next;
    logic             w_accept;
    logic             w_last;
    logic             w_match;
    logic [3:0]       w_r;
    logic [3:0]       w_g;
    logic [3:0]       w_b;
    logic [c_CW-1:0]  w_acc_next [NUM_ZONES];

    logic [NUM_ZONES-1:0]      w_flags;
    logic [NUM_ZONES*c_CW-1:0] w_counts;
    logic [c_ZW-1:0]           w_dom;
    logic [c_CW-1:0]           w_best_cnt;

    // A start-of-packet behaves as though position and accumulators were
    // already cleared, so a pixel arriving alongside it is counted as (0,0).
    always_comb begin
        w_sel    = startofpacket ? colour_sel : r_sel;
        w_zcol   = startofpacket ? '0 : r_zcol;
        w_zone   = startofpacket ? '0 : r_zone;
        w_row    = startofpacket ? '0 : r_row;
        w_accept = valid && (startofpacket || (r_state == ST_COUNT));
        w_last   = w_accept && (w_zcol == c_ZCOL_LAST) &&
                   (w_zone == c_ZONE_LAST) && (w_row == c_ROW_LAST);
    end

    // Colour match
    always_comb begin
        w_r = data_in[11:8];
        w_g = data_in[7:4];
        w_b = data_in[3:0];
        case (w_sel)
            2'b00:   w_match = (w_r >= CH_MIN) && (w_g <= CH_MAX_OTHER) && (w_b <= CH_MAX_OTHER);
            2'b01:   w_match = (w_g >= CH_MIN) && (w_r <= CH_MAX_OTHER) && (w_b <= CH_MAX_OTHER);
            2'b10:   w_match = (w_b >= CH_MIN) && (w_r <= CH_MAX_OTHER) && (w_g <= CH_MAX_OTHER);
            default: w_match = 1'b0;
        endcase
    end

    // Position tracking: zone index steps every c_ZONE_W columns, so no
    // divider is needed to find the zone of a pixel.
    always_comb begin
        w_zcol_next = w_zcol;
        w_zone_next = w_zone;
        w_row_next  = w_row;
        if (w_accept) begin
            if (w_zcol == c_ZCOL_LAST) begin
                w_zcol_next = '0;
                if (w_zone == c_ZONE_LAST) begin
                    w_zone_next = '0;
                    w_row_next  = (w_row == c_ROW_LAST) ? '0 : w_row + c_RW'(1);
                end else begin
                    w_zone_next = w_zone + c_ZW'(1);
                end
            end else begin
                w_zcol_next = w_zcol + c_ZCW'(1);
            end
        end
    end

    // Accumulator update, saturating at the zone pixel count
    always_comb begin
        for (int z = 0; z < NUM_ZONES; z++) begin
            w_acc_next[z] = startofpacket ? '0 : r_acc[z];
            if (w_accept && w_match && (w_zone == c_ZW'(z)) &&
                (w_acc_next[z] != c_ZONE_PIX)) begin
                w_acc_next[z] = w_acc_next[z] + c_CW'(1);
            end
        end
    end

    // Frame results, computed from the counts including the final pixel
    always_comb begin
        w_flags    = '0;
        w_counts   = '0;
        w_dom      = '0;
        w_best_cnt = w_acc_next[0];
        for (int z = 0; z < NUM_ZONES; z++) begin
            w_counts[z*c_CW +: c_CW] = w_acc_next[z];
            w_flags[z] = ((64'(w_acc_next[z]) * 64'd100) >= c_THRESH);
        end
        // Strict greater-than keeps the lowest index on ties
        for (int z = 1; z < NUM_ZONES; z++) begin
            if (w_acc_next[z] > w_best_cnt) begin
                w_best_cnt = w_acc_next[z];
                w_dom      = c_ZW'(z);
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (startofpacket) begin
                    w_state_next = w_last ? ST_IDLE : ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (w_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel  <= 2'b00;
            r_zcol <= '0;
            r_zone <= '0;
            r_row  <= '0;
            for (int z = 0; z < NUM_ZONES; z++) begin
                r_acc[z] <= '0;
            end
        end else begin
            if (startofpacket) begin
                r_sel <= colour_sel;
            end
            r_zcol <= w_zcol_next;
            r_zone <= w_zone_next;
            r_row  <= w_row_next;
            for (int z = 0; z < NUM_ZONES; z++) begin
                r_acc[z] <= w_acc_next[z];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_zone_flags    <= '0;
            r_zone_counts   <= '0;
            r_dominant_zone <= '0;
            r_any_flag      <= 1'b0;
            r_frame_done    <= 1'b0;
        end else begin
            r_frame_done <= w_last;
            if (w_last) begin
                r_zone_flags    <= w_flags;
                r_zone_counts   <= w_counts;
                r_dominant_zone <= w_dom;
                r_any_flag      <= |w_flags;
            end
        end
    end

    assign zone_flags    = r_zone_flags;
    assign zone_counts   = r_zone_counts;
    assign dominant_zone = r_dominant_zone;
    assign any_flag      = r_any_flag;
    assign frame_done    = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_colour_zone_detect.sv
`default_nettype none
// ============================================================================
// Module      : tb_colour_zone_detect
// Description : Self-checking bench for colour_zone_detect. Stimulus drives
//               frames into the DUT and a pixel-index reference model pushes
//               the expected frame result into a queue; an independent
//               monitor pops and compares on every frame_done and checks
//               that results hold between frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_colour_zone_detect;

    localparam int W      = 16;
    localparam int H      = 8;
    localparam int Z      = 4;
    localparam int PCT    = 80;
    localparam int ZPIX_W = W / Z;
    localparam int CW     = $clog2(W * H + 1);
    localparam int IW     = 2;

    logic          clk           = 1'b0;
    logic          reset         = 1'b1;
    logic [11:0]   data_in       = '0;
    logic          valid         = 1'b0;
    logic          startofpacket = 1'b0;
    logic [1:0]    colour_sel    = '0;
    logic [Z-1:0]  zone_flags;
    logic [Z*CW-1:0] zone_counts;
    logic [IW-1:0] dominant_zone;
    logic          any_flag;
    logic          frame_done;

    colour_zone_detect #(
        .IMG_WIDTH      (W),
        .IMG_HEIGHT     (H),
        .NUM_ZONES      (Z),
        .SCREEN_PERCENT (PCT),
        .CH_MIN         (4'hC),
        .CH_MAX_OTHER   (4'h4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .data_in       (data_in),
        .valid         (valid),
        .startofpacket (startofpacket),
        .colour_sel    (colour_sel),
        .zone_flags    (zone_flags),
        .zone_counts   (zone_counts),
        .dominant_zone (dominant_zone),
        .any_flag      (any_flag),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: pixel index within frame, zone = x / strip width
    // ------------------------------------------------------------------------
    typedef struct {
        logic [Z*CW-1:0] counts;
        logic [Z-1:0]    flags;
        logic [IW-1:0]   dom;
        logic            any;
        int              cyc;
    } exp_t;

    exp_t q[$];

    bit m_in  = 1'b0;
    int m_p   = 0;
    int m_sel = 0;
    int m_cnt [Z];

    function automatic bit is_match(input logic [11:0] px, input int sel);
        int ch [3];
        ch[0] = int'(px[11:8]);
        ch[1] = int'(px[7:4]);
        ch[2] = int'(px[3:0]);
        if (sel > 2) return 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == sel) begin
                if (ch[i] < 12) return 1'b0;
            end else begin
                if (ch[i] > 4) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    task automatic push_expected();
        exp_t e;
        int best;
        e.counts = '0;
        e.flags  = '0;
        best     = 0;
        for (int z = 0; z < Z; z++) begin
            e.counts[z*CW +: CW] = CW'(m_cnt[z]);
            e.flags[z] = (m_cnt[z] * 100 >= PCT * ZPIX_W * H);
            if (m_cnt[z] > m_cnt[best]) best = z;
        end
        e.dom = IW'(best);
        e.any = |e.flags;
        e.cyc = cyc;
        q.push_back(e);
    endtask

    task automatic drive(input bit v, input bit sop, input logic [11:0] px, input logic [1:0] sel);
        int x;
        valid         = v;
        startofpacket = sop;
        data_in       = px;
        colour_sel    = sel;
        @(posedge clk);
        #1;
        if (sop) begin
            m_in  = 1'b1;
            m_p   = 0;
            m_sel = int'(sel);
            for (int z = 0; z < Z; z++) m_cnt[z] = 0;
        end
        if (v && m_in) begin
            x = m_p % W;
            if (is_match(px, m_sel)) m_cnt[x / ZPIX_W]++;
            m_p++;
            if (m_p == W * H) begin
                push_expected();
                m_in = 1'b0;
            end
        end
        valid         = 1'b0;
        startofpacket = 1'b0;
    endtask

    function automatic logic [11:0] pix(input int mode, input int x, input int y);
        int          lim [4];
        logic [11:0] pal [10];
        int          k;
        lim = '{26, 25, 32, 0};
        pal = '{12'hF00, 12'h0F0, 12'h00F, 12'hC44, 12'hB44,
                12'hC54, 12'h4C4, 12'h44C, 12'hFFF, 12'h000};
        case (mode)
            0: return 12'hF00;
            1: return (x % 2 == 0) ? 12'hF00 : 12'h000;
            2: return ((y * ZPIX_W + x % ZPIX_W) < lim[x / ZPIX_W]) ? 12'hF00 : 12'h000;
            3: return (x >= 8 && x < 12) ? 12'hF00 : 12'h000;
            4: begin
                k = int'($urandom_range(0, 10));
                return (k == 10) ? 12'($urandom) : pal[k];
            end
            default: return 12'h000;
        endcase
    endfunction

    // gap: 0 none, 1 valid low every other cycle, 2 random gaps and random
    // colour_sel after the frame start
    task automatic send_frame(input int mode, input logic [1:0] sel, input int gap,
                              input bit sop_sep, input int npix);
        if (sop_sep) drive(1'b0, 1'b1, 12'($urandom), sel);
        for (int p = 0; p < npix; p++) begin
            logic [1:0] s;
            bit         first;
            first = (p == 0) && !sop_sep;
            if (gap == 1 && p > 0) drive(1'b0, 1'b0, 12'hF00, sel);
            if (gap == 2 && $urandom_range(0, 3) == 0) drive(1'b0, 1'b0, 12'($urandom), 2'($urandom));
            s = (gap == 2 && !first) ? 2'($urandom) : sel;
            drive(1'b1, first, pix(mode, p % W, p / W), s);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 12'($urandom), 2'($urandom));
    endtask

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    initial begin
        exp_t held;
        exp_t e;
        held.counts = '0;
        held.flags  = '0;
        held.dom    = '0;
        held.any    = 1'b0;
        held.cyc    = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                held.counts = '0;
                held.flags  = '0;
                held.dom    = '0;
                held.any    = 1'b0;
            end
            if (frame_done) begin
                if (q.size() == 0) begin
                    check("unexpected_frame_done", 64'(frame_done), 64'd0);
                end else begin
                    e = q.pop_front();
                    check("zone_counts",   64'(zone_counts),   64'(e.counts));
                    check("zone_flags",    64'(zone_flags),    64'(e.flags));
                    check("dominant_zone", 64'(dominant_zone), 64'(e.dom));
                    check("any_flag",      64'(any_flag),      64'(e.any));
                    check("done_latency",  64'(cyc),           64'(e.cyc));
                    held = e;
                end
            end else begin
                check("hold_results",
                      64'({zone_counts, zone_flags, dominant_zone, any_flag}),
                      64'({held.counts, held.flags, held.dom, held.any}));
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_counts", 64'(zone_counts),   64'd0);
        check("reset_flags",  64'(zone_flags),    64'd0);
        check("reset_dom",    64'(dominant_zone), 64'd0);
        check("reset_any",    64'(any_flag),      64'd0);
        check("reset_done",   64'(frame_done),    64'd0);
        reset = 1'b1;
        idle(2);

        send_frame(0, 2'b00, 0, 1'b0, W * H);          // all red
        idle(3);
        send_frame(1, 2'b00, 0, 1'b0, W * H);          // even columns red
        idle(2);
        send_frame(2, 2'b00, 0, 1'b0, W * H);          // threshold boundary
        idle(2);
        send_frame(3, 2'b00, 0, 1'b0, W * H);          // zone 2 only, red
        send_frame(3, 2'b01, 0, 1'b0, W * H);          // same, green selected
        send_frame(0, 2'b00, 1, 1'b0, W * H);          // red with gaps
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 12'hF00, 2'b00);  // ignored
        idle(2);
        send_frame(0, 2'b00, 0, 1'b0, 50);             // partial, then restart
        send_frame(5, 2'b00, 0, 1'b0, W * H);          // black
        send_frame(0, 2'b11, 0, 1'b1, W * H);          // reserved select, separate SOP
        send_frame(0, 2'b00, 2, 1'b1, W * H);          // red, sel changes mid-frame
        send_frame(0, 2'b00, 0, 1'b0, 40);             // partial frame

        reset = 1'b0;
        m_in  = 1'b0;
        #1;
        check("midreset_counts", 64'(zone_counts), 64'd0);
        check("midreset_flags",  64'(zone_flags),  64'd0);
        check("midreset_any",    64'(any_flag),    64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 30; i++) drive(1'b1, 1'b0, 12'hF00, 2'b00);  // no SOP yet

        for (int f = 0; f < 12; f++) begin
            send_frame(4, 2'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                       1'($urandom_range(0, 1)), W * H);
            idle(int'($urandom_range(0, 3)));
        end

        idle(5);
        check("all_frames_seen", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/colour_zone_detect.md
COLOUR_ZONE_DETECT -- requirements
Module: colour_zone_detect

Interface
REQ-001 Parameter IMG_WIDTH, default 320, pixels per line.
REQ-002 Parameter IMG_HEIGHT, default 240, lines per frame.
REQ-003 Parameter NUM_ZONES, default 4, equal-width vertical strips; SHALL divide IMG_WIDTH exactly (elaboration error otherwise).
REQ-004 Parameter SCREEN_PERCENT, default 80, per-zone match threshold in percent (1..100).
REQ-005 Parameter CH_MIN, default 4'hC, minimum value of the selected channel for a match.
REQ-006 Parameter CH_MAX_OTHER, default 4'h4, maximum value of each non-selected channel for a match.
REQ-007 clk  in  1  sole clock; all logic on its rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-009 data_in  in  12  RGB444 pixel: [11:8] R, [7:4] G, [3:0] B.
REQ-010 valid  in  1  data_in holds a pixel this cycle.
REQ-011 startofpacket  in  1  frame start marker; when valid is also high, data_in is pixel (0,0).
REQ-012 colour_sel  in  2  00 red, 01 green, 10 blue, 11 reserved (never matches).
REQ-013 zone_flags  out  NUM_ZONES  bit z high when zone z met the threshold in the last completed frame.
REQ-014 zone_counts  out  NUM_ZONES*CW  packed matched-pixel counts, zone z at [z*CW +: CW], CW = clog2(IMG_WIDTH*IMG_HEIGHT+1).
REQ-015 dominant_zone  out  max(1,clog2(NUM_ZONES))  index of zone with highest count.
REQ-016 any_flag  out  1  OR of zone_flags.
REQ-017 frame_done  out  1  one-cycle pulse when results update.

Function
REQ-018 FSM states IDLE, COUNT; reset enters IDLE.
REQ-019 IDLE: pixels ignored; startofpacket SHALL clear col, row, zone index and all accumulators, latch colour_sel, enter COUNT.
REQ-020 COUNT: startofpacket SHALL restart as in REQ-019 (partial frame discarded, no frame_done).
REQ-021 SOP cycle with valid high SHALL count that pixel as (0,0); without valid, next valid pixel is (0,0).
REQ-022 col/row advance only on accepted pixels (valid in COUNT, or SOP+valid); gaps in valid SHALL not alter results.
REQ-023 Zone index SHALL be tracked by a counter advancing every IMG_WIDTH/NUM_ZONES columns, resetting at line end; no divider.
REQ-024 Match: selected channel >= CH_MIN and both other channels <= CH_MAX_OTHER; colour_sel 11 never matches.
REQ-025 Matched pixel SHALL increment the accumulator of its zone; accumulators never wrap (max is zone pixel count).
REQ-026 Acceptance of pixel (IMG_WIDTH-1, IMG_HEIGHT-1) SHALL, on the next edge, register zone_counts, zone_flags, dominant_zone, any_flag, pulse frame_done for one cycle, and return to IDLE.
REQ-027 Flag rule: count*100 >= SCREEN_PERCENT*(IMG_WIDTH/NUM_ZONES)*IMG_HEIGHT, evaluated at full width without overflow.
REQ-028 dominant_zone: largest count; ties resolve to the lowest index; all-zero gives 0.
REQ-029 Registered results SHALL hold until the next frame_done or reset.
REQ-030 Pixels after frame completion and before the next startofpacket SHALL be ignored.
REQ-031 colour_sel changes mid-frame SHALL have no effect until the next startofpacket.

Reset
REQ-032 reset low SHALL immediately force IDLE, zero all counters/accumulators, zone_flags=0, zone_counts=0, dominant_zone=0, any_flag=0, frame_done=0.
REQ-033 Reset mid-frame SHALL discard the frame; no frame_done until a full frame follows a new startofpacket.

Verification (defaults: zone 80x240 = 19200 pixels, threshold 15360)
REQ-034 All pixels 12'hF00, colour_sel=00 -> counts 19200 each, zone_flags=4'b1111, any_flag=1, dominant_zone=0, frame_done one cycle after last pixel.
REQ-035 Even columns 12'hF00, odd 12'h000 -> counts 9600 each, zone_flags=0, any_flag=0.
REQ-036 Rows 0-191 red, rest black -> counts 15360, zone_flags=4'b1111; rows 0-190 red -> counts 15280, zone_flags=0.
REQ-037 Columns 160-239 red only: colour_sel=00 -> zone 2 count 19200, zone_flags=4'b0100, dominant_zone=2; colour_sel=01 -> all counts 0, flags 0.
REQ-038 Full red frame with valid low every other cycle -> identical to REQ-034.
REQ-039 startofpacket after 1000 pixels, then full black frame -> no frame_done at restart, final counts 0; reset low mid-frame -> all outputs 0 immediately.
